// File: rtl/outbuf_drain_pkg.sv
// Shared types and constants for the output-side drain buffer.
// The pointer type and the default word width are the same ones used by the input buffer and the PEs.
package outbuf_drain_pkg;

  localparam int PTRW        = 5;
  localparam int CNTW        = 5;
  localparam int DEF_WORDLEN = 16;

  typedef logic [PTRW-1:0] ptr_t;

  // Circular increment: last slot wraps to zero.
  function automatic ptr_t ptr_inc(input ptr_t p, input int unsigned depth);
    return (p == ptr_t'(depth - 1)) ? '0 : p + 1'b1;
  endfunction

endpackage

// File: rtl/outbuf_drain_if.sv
// Bundle of the result-input, drain handshake and status signals of outbuf_drain.
// Input side is valid-only; drain side is valid/ready.
interface outbuf_drain_if #(
  parameter int WORDLEN = outbuf_drain_pkg::DEF_WORDLEN
);

  // in_valid/din: a word is offered every cycle in_valid is high, with no back-pressure.
  // out_valid/out_ready: a word transfers on any cycle where both are high. out_valid
  // never depends on out_ready, and dout is 0 whenever out_valid is low.
  logic                              in_valid;
  logic [WORDLEN-1:0]                din;
  logic                              out_ready;
  logic                              out_valid;
  logic [WORDLEN-1:0]                dout;
  logic                              full;
  logic [outbuf_drain_pkg::CNTW-1:0] count;
  logic                              overflow;

  modport master (
    output in_valid, din, out_ready,
    input  out_valid, dout, full, count, overflow
  );

  modport slave (
    input  in_valid, din, out_ready,
    output out_valid, dout, full, count, overflow
  );

endinterface

// File: rtl/outbuf_drain.sv
// Output FIFO for one PE-array column: drops the first SKIP words after reset, then stores in order.
// Drains over valid/ready with first-word fall-through, and flags words lost to a full buffer.
module outbuf_drain
  import outbuf_drain_pkg::*;
#(
  parameter int WORDLEN = DEF_WORDLEN,
  parameter int BUFSIZE = 10,
  parameter int SKIP    = 0
) (
  input  logic          clk,
  input  logic          rstn,
  outbuf_drain_if.slave bus
);

  localparam int AW = (BUFSIZE > 1) ? $clog2(BUFSIZE) : 1;

  logic [WORDLEN-1:0] bufdat [0:BUFSIZE-1];

  ptr_t            head_q, head_d;
  ptr_t            tail_q, tail_d;
  logic [CNTW-1:0] count_q, count_d;
  logic [CNTW-1:0] skip_q, skip_d;
  logic            ovf_q, ovf_d;

  logic full, out_valid, live, push, pop, drop;

  assign full      = (count_q == CNTW'(BUFSIZE));
  assign out_valid = (count_q != '0);
  assign pop       = out_valid && bus.out_ready;
  // A word arriving after the skip window is either stored or dropped, never both.
  assign live      = bus.in_valid && (skip_q == '0);
  assign push      = live && (!full || pop);
  assign drop      = live && full && !pop;

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (push) tail_d = ptr_inc(tail_q, BUFSIZE);
    if (pop)  head_d = ptr_inc(head_q, BUFSIZE);
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  always_comb begin
    skip_d = skip_q;
    if (bus.in_valid && (skip_q != '0)) skip_d = skip_q - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rstn) skip_q <= CNTW'(SKIP);
    else       skip_q <= skip_d;
  end

  always_comb begin
    ovf_d = ovf_q;
    if (drop) ovf_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rstn) ovf_q <= 1'b0;
    else       ovf_q <= ovf_d;
  end

  // Storage is deliberately not reset; the pointers and count alone define what is valid.
  always_ff @(posedge clk) begin
    if (rstn && push) bufdat[tail_q[AW-1:0]] <= bus.din;
  end

  assign bus.out_valid = out_valid;
  assign bus.dout      = out_valid ? bufdat[head_q[AW-1:0]] : '0;
  assign bus.full      = full;
  assign bus.count     = count_q;
  assign bus.overflow  = ovf_q;

endmodule

// File: tb/tb_outbuf_drain.sv
// Directed bench for outbuf_drain with SKIP=3, BUFSIZE=10: expected words are queued as they are
// driven and popped by an independent monitor on every observed transfer.
module tb_outbuf_drain;
  import outbuf_drain_pkg::*;

  localparam int WL = 16;
  localparam int BS = 10;
  localparam int SK = 3;

  // clock / reset
  logic clk = 1'b0;
  logic rstn;
  always #5 clk = ~clk;

  outbuf_drain_if #(.WORDLEN(WL)) bus ();

  outbuf_drain #(
    .WORDLEN(WL),
    .BUFSIZE(BS),
    .SKIP   (SK)
  ) dut (
    .clk (clk),
    .rstn(rstn),
    .bus (bus)
  );

  int n_pass  = 0;
  int n_total = 0;
  logic [WL-1:0] exp_q[$];
  logic [WL-1:0] mon_e;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // scoreboard monitor: inputs are stable at the falling edge, so a transfer seen here
  // is exactly the one the DUT takes on the next rising edge
  always @(negedge clk) begin
    if (rstn === 1'b1) begin
      if (bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
        if (exp_q.size() == 0) begin
          n_total++;
          $display("FAIL pop_unexpected: got 0x%0h, expected no output at %0t", bus.dout, $time);
        end else begin
          mon_e = exp_q.pop_front();
          check("pop_data", 32'(bus.dout), 32'(mon_e));
        end
      end else if (bus.out_valid !== 1'b1) begin
        check("empty_dout_zero", 32'(bus.dout), 32'h0);
      end
    end
  end

  // driver tasks: inputs change 1 time unit after a rising edge and hold through the next one
  task automatic cyc(input logic v, input logic [WL-1:0] d, input logic r);
    bus.in_valid  = v;
    bus.din       = d;
    bus.out_ready = r;
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [WL-1:0] d, input logic r, input logic stored);
    if (stored) exp_q.push_back(d);
    cyc(1'b1, d, r);
  endtask

  initial begin
    rstn          = 1'b0;
    bus.in_valid  = 1'b0;
    bus.din       = '0;
    bus.out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rstn = 1'b1;
    check("rst_out_valid", 32'(bus.out_valid), 32'h0);
    check("rst_dout",      32'(bus.dout),      32'h0);
    check("rst_full",      32'(bus.full),      32'h0);
    check("rst_count",     32'(bus.count),     32'h0);
    check("rst_overflow",  32'(bus.overflow),  32'h0);

    // skip window: words 1..3 discarded, 4..6 stored
    for (int i = 1; i <= 6; i++) send(WL'(i), 1'b0, (i > SK));
    check("skip_count", 32'(bus.count), 32'd3);
    check("skip_dout",  32'(bus.dout),  32'd4);
    repeat (3) cyc(1'b0, '0, 1'b1);
    check("skip_drained_valid", 32'(bus.out_valid), 32'h0);
    check("skip_drained_dout",  32'(bus.dout),      32'h0);
    cyc(1'b0, '0, 1'b1);
    check("ready_while_empty_count", 32'(bus.count), 32'h0);

    // fill to full, then one dropped word
    for (int i = 0; i < BS; i++) send(WL'(16'hA000 + i), 1'b0, 1'b1);
    check("fill_full",     32'(bus.full),     32'h1);
    check("fill_count",    32'(bus.count),    32'd10);
    check("fill_overflow", 32'(bus.overflow), 32'h0);
    send(16'hBEEF, 1'b0, 1'b0);
    check("drop_overflow", 32'(bus.overflow), 32'h1);
    check("drop_count",    32'(bus.count),    32'd10);
    check("drop_dout",     32'(bus.dout),     32'hA000);

    // full with simultaneous push and pop
    send(16'h0055, 1'b1, 1'b1);
    check("fullpp_dout",     32'(bus.dout),     32'hA001);
    check("fullpp_count",    32'(bus.count),    32'd10);
    check("fullpp_overflow", 32'(bus.overflow), 32'h1);
    repeat (BS) cyc(1'b0, '0, 1'b1);
    check("fullpp_drained", 32'(bus.count), 32'h0);

    // streaming through the wrap point at one word per cycle
    for (int i = 0; i < 25; i++) begin
      send(WL'(16'h0100 + i), 1'b1, 1'b1);
      check("stream_count", 32'(bus.count), 32'd1);
    end
    cyc(1'b0, '0, 1'b1);
    check("stream_drained", 32'(bus.count), 32'h0);

    // empty: no same-cycle bypass
    bus.in_valid  = 1'b1;
    bus.din       = 16'h1234;
    bus.out_ready = 1'b1;
    exp_q.push_back(16'h1234);
    #1;
    check("empty_no_bypass", 32'(bus.out_valid), 32'h0);
    @(posedge clk);
    #1;
    check("empty_next_valid", 32'(bus.out_valid), 32'h1);
    check("empty_next_dout",  32'(bus.dout),      32'h1234);
    cyc(1'b0, '0, 1'b1);
    check("empty_popped", 32'(bus.count), 32'h0);

    // reset mid-stream
    for (int i = 0; i < 5; i++) send(WL'(16'h0600 + i), 1'b0, 1'b1);
    check("pre_rst_count",    32'(bus.count),    32'd5);
    check("pre_rst_overflow", 32'(bus.overflow), 32'h1);
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    rstn = 1'b0;
    @(posedge clk);
    #1;
    rstn = 1'b1;
    exp_q.delete();
    check("mid_rst_count",    32'(bus.count),    32'h0);
    check("mid_rst_overflow", 32'(bus.overflow), 32'h0);
    check("mid_rst_dout",     32'(bus.dout),     32'h0);
    for (int i = 0; i < 5; i++) send(WL'(16'h0700 + i), 1'b0, (i >= SK));
    check("rearm_count", 32'(bus.count), 32'd2);
    check("rearm_dout",  32'(bus.dout),  32'h0703);
    repeat (2) cyc(1'b0, '0, 1'b1);
    check("rearm_drained", 32'(bus.count), 32'h0);
    cyc(1'b0, '0, 1'b0);

    check("exp_q_empty", 32'(exp_q.size()), 32'h0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
